// File: rtl/pwr_pkg.sv
// Shared definitions for the power-estimation stimulus array: mode encodings,
// LFSR tap masks and per-channel seed values.
package pwr_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'd0,
      MODE_LFSR   = 2'd1,
      MODE_TOGGLE = 2'd2,
      MODE_SEED   = 2'd3
   } pwr_mode_e;

   // Feedback taps for the right-shifting Fibonacci LFSR; bit k set means w[k] feeds the XOR.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      logic [31:0] m;
      m = '0;
      case (width)
         8:       m = 32'h0000_001D;
         16:      m = 32'h0000_002D;
         32:      m = 32'hC000_0401;
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] seed(input int unsigned idx, input int unsigned width);
      logic [31:0] s;
      s = idx + 32'd1;
      if (width < 32) s = s & ((32'd1 << width) - 32'd1);
      if (s == '0) s = 32'd1;
      return s;
   endfunction

endpackage

// File: rtl/pwr_stim_ch.sv
// One stimulus channel: activity word with hold/LFSR/toggle/reseed update,
// all-zero lock-up guard and a registered parity fold.
module pwr_stim_ch #(
   parameter int unsigned LFSR_W = 16,
   parameter int unsigned CH_IDX = 0
) (
   input  logic              clk100m,
   input  logic              rst,
   input  logic              tick,
   input  logic              en,
   input  logic [1:0]        mode,
   output logic [LFSR_W-1:0] word,
   output logic              dummy
);
   import pwr_pkg::*;

   localparam logic [LFSR_W-1:0] SEED = LFSR_W'(seed(CH_IDX, LFSR_W));
   localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

   logic [LFSR_W-1:0] word_q;
   logic [LFSR_W-1:0] word_d;
   logic              fb;

   always_comb begin
      word_d = word_q;
      fb     = ^(word_q & TAPS);
      if (tick && en) begin
         case (mode)
            // An all-zero word would never leave zero, so restart from the seed instead.
            MODE_LFSR:   word_d = (word_q == '0) ? SEED : {fb, word_q[LFSR_W-1:1]};
            MODE_TOGGLE: word_d = ~word_q;
            MODE_SEED:   word_d = SEED;
            default:     word_d = word_q;
         endcase
      end
   end

   always_ff @(posedge clk100m or posedge rst) begin
      if (rst) begin
         word_q <= SEED;
         dummy  <= 1'b0;
      end else begin
         word_q <= word_d;
         dummy  <= (^word_q) & en;
      end
   end

   assign word = word_q;

endmodule

// File: rtl/pwr_stim_array.sv
// Array of stimulus channels sharing one update-period divider, registered
// enables and activity mode; channel 0 is mirrored onto the LEDs.
module pwr_stim_array #(
   parameter int unsigned NUM_CH   = 32,
   parameter int unsigned LFSR_W   = 16,
   parameter int unsigned PERIOD_W = 32
) (
   input  logic                     clk100m,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        pwr_en_in,
   input  logic [PERIOD_W-1:0]      period,
   input  logic [1:0]               mode,
   output logic [NUM_CH*LFSR_W-1:0] stim_out,
   output logic [NUM_CH-1:0]        dummy_out,
   output logic                     tick_out,
   output logic [15:0]              leds
);
   import pwr_pkg::*;

   if (!(LFSR_W == 8 || LFSR_W == 16 || LFSR_W == 32)) begin : g_bad_lfsr_w
      $error("pwr_stim_array: LFSR_W must be 8, 16 or 32");
   end
   if (NUM_CH < 1 || NUM_CH > 64) begin : g_bad_num_ch
      $error("pwr_stim_array: NUM_CH must be in 1..64");
   end

   logic [NUM_CH-1:0]   en_q;
   logic [1:0]          mode_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] cnt_q;
   logic                tick;

   // >= rather than == so a period lowered below the running count still ticks next cycle.
   assign tick = (cnt_q >= period_q);

   always_ff @(posedge clk100m or posedge rst) begin
      if (rst) begin
         en_q     <= '0;
         mode_q   <= MODE_HOLD;
         period_q <= '0;
         cnt_q    <= '0;
         tick_out <= 1'b0;
         leds     <= '0;
      end else begin
         en_q     <= pwr_en_in;
         mode_q   <= mode;
         period_q <= period;
         cnt_q    <= tick ? '0 : cnt_q + PERIOD_W'(1);
         tick_out <= tick;
         leds     <= 16'(stim_out[LFSR_W-1:0]);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwr_stim_ch #(
         .LFSR_W (LFSR_W),
         .CH_IDX (i)
      ) u_ch (
         .clk100m (clk100m),
         .rst     (rst),
         .tick    (tick),
         .en      (en_q[i]),
         .mode    (mode_q),
         .word    (stim_out[i*LFSR_W +: LFSR_W]),
         .dummy   (dummy_out[i])
      );
   end

endmodule
